// File: rtl/soc_bus_fabric.sv
// Address decoder, read mux, wait-state FSM and IRQ combiner between the 6502 core and its slaves.
// Optional unmapped-access trap enabled by defining BUS_ERR_EN.
module soc_bus_fabric #(
    parameter int NUM_SLAVES = 4,
    parameter int PAGE_BITS = 4,
    parameter logic [NUM_SLAVES*PAGE_BITS-1:0] SLAVE_BASE = 16'hF210,
    parameter logic [NUM_SLAVES*PAGE_BITS-1:0] SLAVE_MASK = '1,
    parameter logic [NUM_SLAVES*4-1:0] SLAVE_WAIT = '0,
    parameter logic [NUM_SLAVES-1:0] IRQ_MASK = '1,
    parameter int DEFAULT_SLAVE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [15:0]             cpu_ab,
    input  logic                    cpu_we_n,
    output logic [7:0]              cpu_di,
    output logic                    cpu_rdy,
    output logic                    cpu_irq_n,
    output logic [NUM_SLAVES-1:0]   slv_cs_n,
    output logic                    slv_we_n,
    input  logic [8*NUM_SLAVES-1:0] slv_do,
    input  logic [NUM_SLAVES-1:0]   slv_irq_n,
    input  logic                    err_clr,
    output logic                    bus_err,
    output logic [15:0]             err_addr
);

    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [SW-1:0] DEF_IDX = SW'(DEFAULT_SLAVE);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [SW-1:0]   wsel;
    logic [SW-1:0]   sel_q;
    logic            map_q;
    logic            irq_q;
    logic [PAGE_BITS-1:0] page;
    logic            hit_any;
    logic [SW-1:0]   hit_idx;
    logic [SW-1:0]   cur_sel;
    logic            cur_map;
    logic [3:0]      w_cur;

    assign page = cpu_ab[15 -: PAGE_BITS];

    // Scan downward so the lowest matching index is the one left standing.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = DEF_IDX;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if ((page & SLAVE_MASK[k*PAGE_BITS +: PAGE_BITS]) ==
                (SLAVE_BASE[k*PAGE_BITS +: PAGE_BITS] &
                 SLAVE_MASK[k*PAGE_BITS +: PAGE_BITS])) begin
                hit_any = 1'b1;
                hit_idx = SW'(k);
            end
        end
    end

    assign cur_sel = (state == WAIT) ? wsel : hit_idx;

`ifdef BUS_ERR_EN
    assign cur_map = (state == WAIT) | hit_any;
`else
    assign cur_map = 1'b1;
`endif

    assign w_cur = cur_map ? SLAVE_WAIT[cur_sel*4 +: 4] : 4'd0;

    always_comb begin
        if (state == IDLE) cpu_rdy = (w_cur == 4'd0);
        else cpu_rdy = (cnt == 4'd0);
    end

    always_comb begin
        slv_cs_n = '1;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (cur_map && cur_sel == SW'(k)) slv_cs_n[k] = 1'b0;
        end
    end

    assign slv_we_n = cpu_we_n | ~cpu_rdy;
    assign cpu_di = map_q ? slv_do[sel_q*8 +: 8] : 8'hFF;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            wsel  <= DEF_IDX;
        end else begin
            case (state)
                IDLE: begin
                    if (w_cur != 4'd0) begin
                        state <= WAIT;
                        cnt   <= w_cur - 4'd1;
                        wsel  <= hit_idx;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= IDLE;
                    else cnt <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q <= DEF_IDX;
            map_q <= 1'b1;
            irq_q <= 1'b1;
        end else begin
            if (cpu_rdy) begin
                sel_q <= cur_sel;
                map_q <= cur_map;
            end
            irq_q <= &(slv_irq_n | ~IRQ_MASK);
        end
    end

`ifdef BUS_ERR_EN
    logic unmapped;

    assign unmapped = (state == IDLE) & ~hit_any;

    // A new fault outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err  <= 1'b0;
            err_addr <= 16'h0000;
        end else if (unmapped && cpu_rdy) begin
            bus_err <= 1'b1;
            if (!bus_err || err_clr) err_addr <= cpu_ab;
        end else if (err_clr) begin
            bus_err  <= 1'b0;
            err_addr <= 16'h0000;
        end
    end

    assign cpu_irq_n = irq_q & ~bus_err;
`else
    logic unused_ok;

    assign unused_ok = ^{err_clr, hit_any, cpu_ab};
    assign bus_err   = 1'b0;
    assign err_addr  = 16'h0000;
    assign cpu_irq_n = irq_q;
`endif

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Randomised bench for soc_bus_fabric against a transaction-level model of the memory map.
// Expectations for unmapped accesses follow the BUS_ERR_EN build setting.
module tb_soc_bus_fabric;

    localparam int NS = 4;
    localparam int DEF = 1;
    localparam logic [3:0] IMASK = 4'b1101;

`ifdef BUS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // Memory map stated independently of the packed parameters.
    int m_base[NS] = '{4'h0, 4'hC, 4'h2, 4'h0};
    int m_mask[NS] = '{4'hF, 4'hC, 4'hF, 4'h8};
    int m_wait[NS] = '{0, 1, 3, 15};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_ab = 16'h0000;
    logic        cpu_we_n = 1'b1;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic        cpu_irq_n;
    logic [3:0]  slv_cs_n;
    logic        slv_we_n;
    logic [31:0] slv_do = 32'h0;
    logic [3:0]  slv_irq_n = 4'hF;
    logic        err_clr = 1'b0;
    logic        bus_err;
    logic [15:0] err_addr;

    int vectors = 0;
    int miscompares = 0;

    bit          m_berr = 1'b0;
    logic [15:0] m_eaddr = 16'h0000;
    bit          m_irq = 1'b1;

    soc_bus_fabric #(
        .NUM_SLAVES(NS),
        .PAGE_BITS(4),
        .SLAVE_BASE({4'h0, 4'h2, 4'hC, 4'h0}),
        .SLAVE_MASK({4'h8, 4'hF, 4'hC, 4'hF}),
        .SLAVE_WAIT({4'hF, 4'h3, 4'h1, 4'h0}),
        .IRQ_MASK(IMASK),
        .DEFAULT_SLAVE(DEF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cpu_ab(cpu_ab),
        .cpu_we_n(cpu_we_n),
        .cpu_di(cpu_di),
        .cpu_rdy(cpu_rdy),
        .cpu_irq_n(cpu_irq_n),
        .slv_cs_n(slv_cs_n),
        .slv_we_n(slv_we_n),
        .slv_do(slv_do),
        .slv_irq_n(slv_irq_n),
        .err_clr(err_clr),
        .bus_err(bus_err),
        .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    function automatic int decode(input logic [15:0] a);
        int p;
        p = int'(a[15:12]);
        for (int k = 0; k < NS; k++)
            if ((p & m_mask[k]) == (m_base[k] & m_mask[k])) return k;
        return -1;
    endfunction

    // One CPU access held until completion; clr pulses err_clr on the completing cycle.
    task automatic access(input logic [15:0] a, input logic we, input logic clr);
        int t;
        int w;
        bit unm;
        bit exp_rdy;
        logic [3:0] exp_cs;
        logic [7:0] exp_di;
        t = decode(a);
        unm = (t < 0);
        if (unm && !ERR_EN) t = DEF;
        w = (t < 0) ? 0 : m_wait[t];
        exp_cs = (t < 0) ? 4'hF : ~(4'b0001 << t);
        slv_do = $urandom;
        cpu_ab = a;
        cpu_we_n = we;
        for (int c = 0; c <= w; c++) begin
            exp_rdy = (c == w);
            if (exp_rdy) err_clr = clr;
            @(negedge clk);
            vectors++;
            if (cpu_rdy !== exp_rdy) begin
                miscompares++;
                $display("FAIL rdy a=%h cyc=%0d got=%b exp=%b", a, c, cpu_rdy, exp_rdy);
            end
            vectors++;
            if (slv_cs_n !== exp_cs) begin
                miscompares++;
                $display("FAIL cs a=%h cyc=%0d got=%b exp=%b", a, c, slv_cs_n, exp_cs);
            end
            vectors++;
            if (slv_we_n !== (we | !exp_rdy)) begin
                miscompares++;
                $display("FAIL we a=%h cyc=%0d got=%b exp=%b", a, c, slv_we_n,
                         we | !exp_rdy);
            end
        end
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        if (unm && ERR_EN) begin
            if (!m_berr || clr) m_eaddr = a;
            m_berr = 1'b1;
        end else if (clr && ERR_EN) begin
            m_berr = 1'b0;
            m_eaddr = 16'h0000;
        end
        exp_di = (t < 0) ? 8'hFF : slv_do[t*8 +: 8];
        vectors++;
        if (cpu_di !== exp_di) begin
            miscompares++;
            $display("FAIL di a=%h got=%h exp=%h", a, cpu_di, exp_di);
        end
        vectors++;
        if (bus_err !== m_berr || err_addr !== m_eaddr) begin
            miscompares++;
            $display("FAIL err a=%h got=%b/%h exp=%b/%h", a, bus_err, err_addr,
                     m_berr, m_eaddr);
        end
        vectors++;
        if (cpu_irq_n !== (m_irq & !m_berr)) begin
            miscompares++;
            $display("FAIL irq_acc a=%h got=%b exp=%b", a, cpu_irq_n, m_irq & !m_berr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_ab = 16'h0000;
        slv_do = 32'hA5C3_7E19;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (cpu_irq_n !== 1'b1 || bus_err !== 1'b0 || err_addr !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_flags got=%b/%b/%h exp=1/0/0000", cpu_irq_n, bus_err, err_addr);
        end
        vectors++;
        if (cpu_di !== slv_do[DEF*8 +: 8]) begin
            miscompares++;
            $display("FAIL reset_di got=%h exp=%h", cpu_di, slv_do[DEF*8 +: 8]);
        end
        vectors++;
        if (cpu_rdy !== 1'b1 || slv_cs_n !== 4'b1110) begin
            miscompares++;
            $display("FAIL reset_dec got=%b/%b exp=1/1110", cpu_rdy, slv_cs_n);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_berr = 1'b0;
        m_eaddr = 16'h0000;
        m_irq = 1'b1;
    endtask

    task automatic test_directed();
        access(16'h0123, 1'b1, 1'b0);
        access(16'h2001, 1'b0, 1'b0);
        access(16'h0000, 1'b1, 1'b0);
        access(16'h5000, 1'b0, 1'b0);
        access(16'hE000, 1'b0, 1'b0);
        access(16'hAABC, 1'b1, 1'b0);
        access(16'h8000, 1'b1, 1'b0);
        access(16'h0040, 1'b1, 1'b1);
        access(16'h9123, 1'b0, 1'b0);
        access(16'hB777, 1'b1, 1'b1);
        access(16'h0001, 1'b1, 1'b1);
    endtask

    task automatic test_irq();
        slv_irq_n = 4'b1101;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (cpu_irq_n !== !m_berr) begin
            miscompares++;
            $display("FAIL irq_masked got=%b exp=%b", cpu_irq_n, !m_berr);
        end
        slv_irq_n = 4'b1001;
        @(negedge clk);
        vectors++;
        if (cpu_irq_n !== !m_berr) begin
            miscompares++;
            $display("FAIL irq_early got=%b exp=%b", cpu_irq_n, !m_berr);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (cpu_irq_n !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_slave2 got=%b exp=0", cpu_irq_n);
        end
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            bit e;
            v = 4'($urandom);
            slv_irq_n = v;
            e = 1'b1;
            for (int k = 0; k < NS; k++)
                if (IMASK[k] && !v[k]) e = 1'b0;
            @(posedge clk);
            #1;
            vectors++;
            if (cpu_irq_n !== (e & !m_berr)) begin
                miscompares++;
                $display("FAIL irq_rand v=%b got=%b exp=%b", v, cpu_irq_n, e & !m_berr);
            end
        end
        slv_irq_n = 4'hF;
        @(posedge clk);
        #1;
        m_irq = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        cpu_ab = 16'h2001;
        cpu_we_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (c == 1) reset = 1'b1;
            @(negedge clk);
            vectors++;
            if (cpu_rdy !== 1'b0 || slv_we_n !== 1'b1) begin
                miscompares++;
                $display("FAIL rst_wait cyc=%0d got=%b/%b exp=0/1", c, cpu_rdy, slv_we_n);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        m_berr = 1'b0;
        m_eaddr = 16'h0000;
        access(16'h2001, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            logic [15:0] a;
            a = 16'($urandom);
            access(a, 1'($urandom), ($urandom_range(0, 7) == 0));
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            access({4'h0, 12'($urandom)}, 1'($urandom), 1'b0);
            access({4'h2, 12'($urandom)}, 1'($urandom), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_irq();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
